// File: rtl/apb_slave.sv
// rtl/apb_slave.sv - APB completer with an 8x8 register bank, R7 transfer counter, WAIT_CYCLES wait states; optional slverr port under APB_SLAVE_SLVERR_EN
module apb_slave #(
    parameter logic [1:0]  SLAVE_ID    = 2'b01,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel,
    input  logic       enable,
    input  logic       write,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ready
`ifdef APB_SLAVE_SLVERR_EN
    ,
    output logic       slverr
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [3:0] wait_cnt;

    // Transfer attributes captured when the SETUP phase opens
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic       write_q;

    logic [7:0] regs [8];

    logic selected;
    logic start;
    logic keep_going;
    logic addr_in_bank;
    logic wr_en;

    assign selected   = (sel == SLAVE_ID);
    // A selected cycle with enable low opens a new SETUP phase
    assign start      = selected && !enable;
    // The requester keeps the access phase alive with sel and enable both held
    assign keep_going = selected && enable;

    // Only addresses 0..7 map onto the bank; anything above completes as a no-op
    assign addr_in_bank = (addr_q[7:3] == 5'd0);

    // Completion strobe: last ACCESS cycle once the wait counter has drained
    assign ready = !reset && (state == ST_ACCESS) && (wait_cnt == 4'd0);

    // R7 is the transfer counter and can never be written from the bus
    assign wr_en = ready && write_q && addr_in_bank && (addr_q[2:0] != 3'd7);

    // Read data is the register value ahead of any update at the completing edge
    assign rdata = (ready && addr_in_bank) ? regs[addr_q[2:0]] : 8'h00;

`ifdef APB_SLAVE_SLVERR_EN
    // Error flags out-of-bank accesses and attempted writes to the counter
    assign slverr = ready && (!addr_in_bank || (write_q && (addr_q[2:0] == 3'd7)));
`endif

    // Next-state decode for IDLE / SETUP / ACCESS
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_nxt = keep_going ? ST_ACCESS : ST_IDLE;
            end
            ST_ACCESS: begin
                if (ready) begin
                    state_nxt = start ? ST_SETUP : ST_IDLE;
                end else if (!keep_going) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register and wait-state counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_nxt;
            if (state == ST_SETUP && state_nxt == ST_ACCESS) begin
                wait_cnt <= WAIT_INIT;
            end else if (state == ST_ACCESS && state_nxt == ST_ACCESS && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end else if (state_nxt != ST_ACCESS) begin
                wait_cnt <= 4'd0;
            end
        end
    end

    // Capture address, direction and data on every entry into SETUP
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            write_q <= 1'b0;
        end else if (state_nxt == ST_SETUP) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            write_q <= write;
        end
    end

    // Register bank: bus writes to R0..R6, R7 counts every completed transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            if (wr_en) begin
                regs[addr_q[2:0]] <= wdata_q;
            end
            if (ready) begin
                regs[7] <= regs[7] + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_apb_slave.sv
// tb/tb_apb_slave.sv - self-checking bench for apb_slave with zero and three wait states
module tb_apb_slave;

    localparam logic [1:0] ID = 2'b01;

    typedef struct packed {
        logic       rdy;
        logic       chk_rd;
        logic [7:0] rd;
        logic       err;
    } exp_t;

    localparam exp_t IDLE_E = '0;

    logic       clk;
    logic       reset;
    logic [1:0] sel    [2];
    logic       enable [2];
    logic       write  [2];
    logic [7:0] addr   [2];
    logic [7:0] wdata  [2];
    logic [7:0] rdata  [2];
    logic       ready  [2];
`ifdef APB_SLAVE_SLVERR_EN
    logic       slverr [2];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mreg [2][8];
    logic [7:0] last_rd [2];
    exp_t q0[$];
    exp_t q1[$];

    apb_slave #(.SLAVE_ID(ID), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .sel(sel[0]), .enable(enable[0]), .write(write[0]),
        .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0])
`ifdef APB_SLAVE_SLVERR_EN
        , .slverr(slverr[0])
`endif
    );

    apb_slave #(.SLAVE_ID(ID), .WAIT_CYCLES(3)) u_dut1 (
        .clk(clk), .reset(reset), .sel(sel[1]), .enable(enable[1]), .write(write[1]),
        .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1])
`ifdef APB_SLAVE_SLVERR_EN
        , .slverr(slverr[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int waits(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: outcome of one completed transfer, then the bank update
    function automatic exp_t model_complete(input int d, input logic wr, input logic [7:0] a,
                                            input logic [7:0] wd);
        exp_t e;
        e.rdy    = 1'b1;
        e.chk_rd = !wr;
        e.rd     = (a < 8) ? mreg[d][a[2:0]] : 8'h00;
        e.err    = (a >= 8) || (wr && a == 8'd7);
        if (wr && a < 7) mreg[d][a[2:0]] = wd;
        mreg[d][7] = mreg[d][7] + 8'd1;
        return e;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 8; r++)
                mreg[k][r] = 8'h00;
    endtask

    task automatic check_dut(input int k, input exp_t e);
        chk($sformatf("ready_dut%0d", k), ready[k], e.rdy);
        if (!e.rdy) chk($sformatf("rdata_zero_dut%0d", k), rdata[k], 8'h00);
        else if (e.chk_rd) chk($sformatf("rdata_dut%0d", k), rdata[k], e.rd);
`ifdef APB_SLAVE_SLVERR_EN
        chk($sformatf("slverr_dut%0d", k), slverr[k], e.err);
`endif
        if (ready[k] === 1'b1) last_rd[k] = rdata[k];
    endtask

    // Single compare process: every driven cycle carries an expectation for both DUTs
    always @(negedge clk) begin : cmp
        exp_t e0;
        exp_t e1;
        if (q0.size() != 0 && q1.size() != 0) begin
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            check_dut(0, e0);
            check_dut(1, e1);
        end
    end

    // One bus cycle on DUT d; the other DUT sees an idle bus
    task automatic cyc(input int d, input logic [1:0] s, input logic en, input logic wr,
                       input logic [7:0] a, input logic [7:0] wd, input exp_t e);
        for (int k = 0; k < 2; k++) begin
            if (k == d) begin
                sel[k] = s; enable[k] = en; write[k] = wr; addr[k] = a; wdata[k] = wd;
            end else begin
                sel[k] = 2'b00; enable[k] = 1'b0; write[k] = 1'b0; addr[k] = 8'h00; wdata[k] = 8'h00;
            end
        end
        q0.push_back((d == 0) ? e : IDLE_E);
        q1.push_back((d == 1) ? e : IDLE_E);
        @(posedge clk);
        #1;
    endtask

    // SETUP cycle plus wait cycles; data inputs are scrambled to prove they were latched
    task automatic access(input int d, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                          output exp_t e);
        cyc(d, ID, 1'b1, ~wr, ~a, ~wd, IDLE_E);
        for (int i = 0; i < waits(d); i++) cyc(d, ID, 1'b1, ~wr, ~a, ~wd, IDLE_E);
        e = model_complete(d, wr, a, wd);
    endtask

    task automatic xfer(input int d, input logic wr, input logic [7:0] a, input logic [7:0] wd);
        exp_t e;
        cyc(d, ID, 1'b0, wr, a, wd, IDLE_E);
        access(d, wr, a, wd, e);
        cyc(d, ID, 1'b1, ~wr, ~a, ~wd, e);
        cyc(d, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, IDLE_E);
    endtask

    initial begin : stim
        exp_t e;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            sel[k] = 2'b00; enable[k] = 1'b0; write[k] = 1'b0; addr[k] = 8'h00; wdata[k] = 8'h00;
            last_rd[k] = 8'h00;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cyc(0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, IDLE_E);
        cyc(0, ID, 1'b0, 1'b1, 8'h03, 8'h99, IDLE_E);
        reset = 1'b0;

        // Zero wait states: write A5 to R3, read it back, then the counter
        xfer(0, 1'b1, 8'h03, 8'hA5);
        xfer(0, 1'b0, 8'h03, 8'h00);
        chk("read_r3_a5", last_rd[0], 8'hA5);
        xfer(0, 1'b0, 8'h07, 8'h00);
        chk("r7_after_two", last_rd[0], 8'h02);

        // SETUP abandoned by deselect, then by enable staying low
        cyc(0, ID, 1'b0, 1'b1, 8'h04, 8'h77, IDLE_E);
        cyc(0, 2'b10, 1'b1, 1'b1, 8'h04, 8'h77, IDLE_E);
        cyc(0, ID, 1'b0, 1'b1, 8'h04, 8'h77, IDLE_E);
        cyc(0, ID, 1'b0, 1'b1, 8'h04, 8'h77, IDLE_E);
        cyc(0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, IDLE_E);

        // Another completer addressed: everything ignored
        cyc(0, 2'b10, 1'b0, 1'b1, 8'h03, 8'hEE, IDLE_E);
        cyc(0, 2'b10, 1'b1, 1'b1, 8'h03, 8'hEE, IDLE_E);
        cyc(0, 2'b11, 1'b0, 1'b1, 8'h05, 8'hEE, IDLE_E);
        cyc(0, 2'b11, 1'b1, 1'b1, 8'h05, 8'hEE, IDLE_E);

        xfer(0, 1'b0, 8'h04, 8'h00);
        chk("r4_untouched", last_rd[0], 8'h00);
        xfer(0, 1'b0, 8'h03, 8'h00);
        xfer(0, 1'b0, 8'h0B, 8'h00);
        chk("oob_read_0b", last_rd[0], 8'h00);
        xfer(0, 1'b0, 8'h07, 8'h00);
        chk("r7_count_dut0", last_rd[0], 8'h06);

        // Three wait states
        xfer(1, 1'b0, 8'h00, 8'h00);
        chk("ws3_read_r0", last_rd[1], 8'h00);
        xfer(1, 1'b1, 8'h07, 8'h55);
        xfer(1, 1'b1, 8'h09, 8'h11);
        xfer(1, 1'b0, 8'h09, 8'h00);
        chk("oob_read_09", last_rd[1], 8'h00);
        xfer(1, 1'b0, 8'h07, 8'h00);
        chk("r7_not_written", last_rd[1], 8'h04);

        // Enable dropped in an ACCESS wait cycle of a write of FF to R1
        cyc(1, ID, 1'b0, 1'b1, 8'h01, 8'hFF, IDLE_E);
        cyc(1, ID, 1'b1, 1'b1, 8'h01, 8'hFF, IDLE_E);
        cyc(1, ID, 1'b1, 1'b1, 8'h01, 8'hFF, IDLE_E);
        cyc(1, ID, 1'b0, 1'b1, 8'h01, 8'hFF, IDLE_E);
        cyc(1, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, IDLE_E);
        xfer(1, 1'b0, 8'h01, 8'h00);
        chk("abort_r1", last_rd[1], 8'h00);
        xfer(1, 1'b0, 8'h07, 8'h00);
        chk("abort_r7", last_rd[1], 8'h06);

        // Reset in the ACCESS of a write of 3C to R2
        cyc(1, ID, 1'b0, 1'b1, 8'h02, 8'h3C, IDLE_E);
        cyc(1, ID, 1'b1, 1'b1, 8'h02, 8'h3C, IDLE_E);
        reset = 1'b1;
        cyc(1, ID, 1'b1, 1'b1, 8'h02, 8'h3C, IDLE_E);
        reset = 1'b0;
        model_reset();
        xfer(1, 1'b0, 8'h07, 8'h00);
        chk("rst_r7", last_rd[1], 8'h00);
        xfer(1, 1'b0, 8'h02, 8'h00);
        chk("rst_r2", last_rd[1], 8'h00);

        // 256 back-to-back counter reads on the zero-wait completer
        cyc(0, ID, 1'b0, 1'b0, 8'h07, 8'h00, IDLE_E);
        for (int i = 0; i < 256; i++) begin
            access(0, 1'b0, 8'h07, 8'h00, e);
            if (i < 255) cyc(0, ID, 1'b0, 1'b0, 8'h07, 8'h00, e);
            else         cyc(0, ID, 1'b1, 1'b0, 8'h07, 8'h00, e);
        end
        chk("b2b_last", last_rd[0], 8'hFF);
        cyc(0, 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, IDLE_E);
        xfer(0, 1'b0, 8'h07, 8'h00);
        chk("r7_wrapped", last_rd[0], 8'h00);
        xfer(0, 1'b0, 8'h03, 8'h00);
        chk("rst_cleared_dut0", last_rd[0], 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
